// File: rtl/sqm_pkg.sv
// Shared definitions for the SQmusic envelope generator: shape bit
// positions, envelope FSM state encoding and the amplitude-code helper.
package sqm_pkg;

  // Bit positions inside the 4-bit shape word {CONT,ATT,ALT,HOLD}
  localparam int SH_HOLD = 0;
  localparam int SH_ALT  = 1;
  localparam int SH_ATT  = 2;
  localparam int SH_CONT = 3;

  // Highest amplitude code, also the last step of a 16-step envelope cycle
  localparam logic [3:0] ENV_MAX = 4'hF;

  // Envelope FSM: counting through a cycle, or frozen on a held code
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } env_state_e;

  // Amplitude code from the step counter; inv mirrors a ramp into a decay
  function automatic logic [3:0] env_code(input logic [3:0] cnt, input logic inv);
    return cnt ^ {4{inv}};
  endfunction

endpackage

// File: rtl/sqm_env_timebase.sv
// Envelope timebase: divides chip-rate enables by PRESCALE, then by the
// live period value, and emits a one-clk registered step pulse per period.
module sqm_env_timebase #(
  parameter int PRESCALE = 16,
  parameter int PW       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_en_i,
  input  logic          restart_i,
  input  logic [PW-1:0] period_i,
  output logic          step_o
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PW-1:0]    per_q, per_d;
  logic [PW-1:0]    per_lim_s;
  logic             step_q, step_d;

  // Next-state of prescaler/period counter; a restart discards any pending count
  always_comb begin
    pre_d  = pre_q;
    per_d  = per_q;
    step_d = 1'b0;
    // period 0 acts as period 1; >= compare so a lowered period fires promptly
    if (period_i == {PW{1'b0}}) begin
      per_lim_s = {PW{1'b0}};
    end else begin
      per_lim_s = period_i - PW'(1);
    end
    if (restart_i) begin
      pre_d = {PRE_W{1'b0}};
      per_d = {PW{1'b0}};
    end else if (clk_en_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d = {PRE_W{1'b0}};
        if (per_q >= per_lim_s) begin
          per_d  = {PW{1'b0}};
          step_d = 1'b1;
        end else begin
          per_d = per_q + PW'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = pre_q;
      per_d = per_q;
    end
  end

  // Timebase registers; step is registered so it is a clean one-clk pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= {PRE_W{1'b0}};
      per_q  <= {PW{1'b0}};
      step_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      per_q  <= per_d;
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/sqm_envelope_gen.sv
// AY-3-8910-compatible envelope generator: 16-step amplitude ramp shaped by
// CONT/ATT/ALT/HOLD, advanced by the timebase step pulse.
module sqm_envelope_gen
  import sqm_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PW       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_en,
  input  logic [PW-1:0] period,
  input  logic [3:0]    shape,
  input  logic          shape_wr,
  output logic [3:0]    env,
  output logic          holding
);

  logic       step_s;
  logic [3:0] shape_q;
  logic [3:0] cnt_q;
  logic       inv_q;
  env_state_e state_q;
  logic [3:0] env_q;
  logic       holding_q;

  sqm_env_timebase #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_timebase (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en_i  (clk_en),
    .restart_i (shape_wr),
    .period_i  (period),
    .step_o    (step_s)
  );

  // RUN/HOLD envelope FSM with registered amplitude and holding flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shape_q   <= 4'h0;
      cnt_q     <= 4'h0;
      inv_q     <= 1'b0;
      state_q   <= ST_HOLD;
      env_q     <= 4'h0;
      holding_q <= 1'b1;
    end else if (shape_wr) begin
      // shape write restarts the envelope and wins over a coincident step
      shape_q   <= shape;
      cnt_q     <= 4'h0;
      inv_q     <= ~shape[SH_ATT];
      state_q   <= ST_RUN;
      env_q     <= env_code(4'h0, ~shape[SH_ATT]);
      holding_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (step_s) begin
            if (cnt_q != ENV_MAX) begin
              cnt_q <= cnt_q + 4'd1;
              env_q <= env_code(cnt_q + 4'd1, inv_q);
            end else if (!shape_q[SH_CONT]) begin
              // single-shot shapes always settle silent
              state_q   <= ST_HOLD;
              env_q     <= 4'h0;
              holding_q <= 1'b1;
            end else if (shape_q[SH_HOLD]) begin
              // hold the last code, optionally flipped by ALT
              state_q   <= ST_HOLD;
              env_q     <= env_q ^ {4{shape_q[SH_ALT]}};
              holding_q <= 1'b1;
            end else begin
              // continuous: wrap, ALT turns a sawtooth into a triangle
              cnt_q <= 4'h0;
              inv_q <= inv_q ^ shape_q[SH_ALT];
              env_q <= env_code(4'h0, inv_q ^ shape_q[SH_ALT]);
            end
          end
        end
        ST_HOLD: begin
          state_q <= ST_HOLD;
        end
        default: begin
          state_q   <= ST_HOLD;
          env_q     <= 4'h0;
          holding_q <= 1'b1;
        end
      endcase
    end
  end

  assign env     = env_q;
  assign holding = holding_q;

endmodule

// File: tb/tb_sqm_envelope_gen.sv
// Directed self-checking bench for sqm_envelope_gen (PRESCALE=16, PW=16).
module tb_sqm_envelope_gen;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        shape_wr;
  logic [3:0]  env;
  logic        holding;

  int n_cmp;
  int n_err;

  sqm_envelope_gen #(
    .PRESCALE (16),
    .PW       (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .period   (period),
    .shape    (shape),
    .shape_wr (shape_wr),
    .env      (env),
    .holding  (holding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n clk_en pulses; each ends one clk after the step could reach env
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) clk_en = 1'b1;
      @(negedge clk) clk_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wr_shape(input logic [3:0] s);
    @(negedge clk);
    shape    = s;
    shape_wr = 1'b1;
    @(negedge clk);
    shape_wr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    clk_en   = 1'b0;
    period   = 16'd1;
    shape    = 4'h0;
    shape_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_env", 16'(env), 16'd0);
    chk("rst_holding", 16'(holding), 16'd1);
    reset_n = 1'b1;

    // 1: no shape write -> silent and holding
    for (int i = 0; i < 1000; i++) begin
      pulses(1);
      chk("t1_env", 16'(env), 16'd0);
      chk("t1_holding", 16'(holding), 16'd1);
    end

    // 2: shape 8 sawtooth down, period 1, three cycles
    period = 16'd1;
    wr_shape(4'b1000);
    chk("t2_env0", 16'(env), 16'd15);
    chk("t2_holding0", 16'(holding), 16'd0);
    for (int k = 1; k <= 48; k++) begin
      pulses(15);
      chk("t2_pre", 16'(env), 16'(15 - ((k - 1) % 16)));
      pulses(1);
      chk("t2_step", 16'(env), 16'(15 - (k % 16)));
      chk("t2_holding", 16'(holding), 16'd0);
    end

    // 3: shape 13, period 2 -> ramp up, hold 15
    period = 16'd2;
    wr_shape(4'b1101);
    chk("t3_env0", 16'(env), 16'd0);
    for (int k = 1; k <= 15; k++) begin
      pulses(31);
      chk("t3_pre", 16'(env), 16'(k - 1));
      pulses(1);
      chk("t3_step", 16'(env), 16'(k));
      chk("t3_holding", 16'(holding), 16'd0);
    end
    pulses(32);
    chk("t3_hold_env", 16'(env), 16'd15);
    chk("t3_hold_flag", 16'(holding), 16'd1);
    pulses(64);
    chk("t3_hold_env2", 16'(env), 16'd15);
    chk("t3_hold_flag2", 16'(holding), 16'd1);

    // 4: shape 14 triangle, period 0 then period 1, same trace
    for (int p = 0; p < 2; p++) begin
      period = 16'(p);
      wr_shape(4'b1110);
      chk("t4_env0", 16'(env), 16'd0);
      for (int k = 1; k < 48; k++) begin
        pulses(16);
        e = (((k / 16) % 2) == 1) ? (15 - (k % 16)) : (k % 16);
        chk("t4_tri", 16'(env), 16'(e));
      end
    end

    // 5: shape 0 mid-run, then shape 11 coincident with a step
    period = 16'd1;
    wr_shape(4'b0000);
    chk("t5_env0", 16'(env), 16'd15);
    pulses(48);
    chk("t5_mid", 16'(env), 16'd12);
    pulses(15);
    chk("t5_prewr", 16'(env), 16'd12);
    @(negedge clk) clk_en = 1'b1;
    @(negedge clk);
    clk_en   = 1'b0;
    shape    = 4'b1011;
    shape_wr = 1'b1;
    @(negedge clk);
    shape_wr = 1'b0;
    chk("t5_coinc_env", 16'(env), 16'd15);
    chk("t5_coinc_holding", 16'(holding), 16'd0);
    pulses(15);
    chk("t5_nostep", 16'(env), 16'd15);
    pulses(1);
    chk("t5_first", 16'(env), 16'd14);
    for (int k = 2; k <= 15; k++) begin
      pulses(16);
      chk("t5_decay", 16'(env), 16'(15 - k));
    end
    pulses(16);
    chk("t5_hold_env", 16'(env), 16'd15);
    chk("t5_hold_flag", 16'(holding), 16'd1);
    shape = 4'b1000;
    pulses(32);
    chk("t5_shape_nowr", 16'(env), 16'd15);
    chk("t5_shape_nowr_h", 16'(holding), 16'd1);

    // 6: async reset during shape 12 at cnt 7
    wr_shape(4'b1100);
    pulses(7 * 16);
    chk("t6_cnt7", 16'(env), 16'd7);
    pulses(5);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_env", 16'(env), 16'd0);
    chk("t6_async_holding", 16'(holding), 16'd1);
    @(negedge clk) reset_n = 1'b1;
    pulses(20);
    chk("t6_post_env", 16'(env), 16'd0);
    chk("t6_post_holding", 16'(holding), 16'd1);
    wr_shape(4'b1100);
    chk("t6_wr_env", 16'(env), 16'd0);
    chk("t6_wr_holding", 16'(holding), 16'd0);
    pulses(16);
    chk("t6_step1", 16'(env), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
